// File: rtl/seq_barrel_shifter.sv
// Multi-cycle barrel shifter: LSL/LSR/ASR/ROR moving up to STEP bits per clock.
// Uses a start/busy/done handshake and reports carry, overflow and zero flags.
// Optional feature macro: SEQ_SHIFTER_ROR_EN. When it is undefined, mode 11 passes the
// operand through in one step and no rotate logic is built.
// WIDTH must equal 2**SHW; wrap-around index arithmetic relies on this.
module seq_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] ModeLsl = 2'b00;
  localparam logic [1:0] ModeLsr = 2'b01;
  localparam logic [1:0] ModeAsr = 2'b10;
  localparam logic [1:0] ModeRor = 2'b11;

  // STEP >= WIDTH behaves like WIDTH-1, because rem never exceeds WIDTH-1.
  localparam logic [SHW-1:0] StepS   = (STEP >= WIDTH) ? SHW'(WIDTH - 1) : SHW'(STEP);
  localparam logic [SHW-1:0] MaxIdx  = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] IdxZero = '0;
  localparam logic [WIDTH-1:0] AllOnes = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       mode_q, mode_d;
  logic             sign_q, sign_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic             cacc_q, cacc_d;
  logic             oacc_q, oacc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SHW-1:0]   step_s;
  logic [WIDTH-1:0] step_res;
  logic             step_carry;
  logic             step_ovf;

  // One shift step of s = min(STEP, rem) bits in the latched mode.
  always_comb begin
    step_s     = (rem_q < StepS) ? rem_q : StepS;
    step_res   = work_q;
    step_carry = 1'b0;
    step_ovf   = 1'b0;
    case (mode_q)
      ModeLsl: begin
        step_res   = work_q << step_s;
        // IdxZero - s wraps to WIDTH - s.
        step_carry = work_q[IdxZero - step_s];
        // Any bit in [WIDTH-1 : WIDTH-1-s] that differs from the sign bit.
        step_ovf   = |((work_q ^ {WIDTH{work_q[WIDTH-1]}}) >> (MaxIdx - step_s));
      end
      ModeLsr: begin
        step_res   = work_q >> step_s;
        step_carry = work_q[step_s - 1'b1];
      end
      ModeAsr: begin
        step_res   = (work_q >> step_s) | (~(AllOnes >> step_s) & {WIDTH{sign_q}});
        step_carry = work_q[step_s - 1'b1];
      end
`ifdef SEQ_SHIFTER_ROR_EN
      ModeRor: begin
        step_res   = (work_q >> step_s) | (work_q << (IdxZero - step_s));
        step_carry = work_q[step_s - 1'b1];
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic. Result registers load only on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    cacc_d  = cacc_q;
    oacc_d  = oacc_q;
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          work_d  = in_i;
          mode_d  = mode_i;
          sign_d  = in_i[WIDTH-1];
          rem_d   = amt_i;
          cacc_d  = 1'b0;
          oacc_d  = 1'b0;
          state_d = StShift;
`ifndef SEQ_SHIFTER_ROR_EN
          // Pass-through: a zero-length operation finishes on the first SHIFT edge.
          if (mode_i == ModeRor) rem_d = '0;
`endif
        end
      end
      StShift: begin
        if (step_s != '0) begin
          work_d = step_res;
          cacc_d = step_carry;
          oacc_d = oacc_q | step_ovf;
        end
        rem_d = rem_q - step_s;
        if (rem_d == '0) begin
          state_d = StDone;
          out_d   = work_d;
          carry_d = cacc_d;
          ovf_d   = oacc_d;
          zero_d  = (work_d == '0);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      work_q  <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      cacc_q  <= 1'b0;
      oacc_q  <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      cacc_q  <= cacc_d;
      oacc_q  <= oacc_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake status is decoded directly from the state.
  always_comb begin
    busy_o     = (state_q == StShift);
    done_o     = (state_q == StDone);
    out_o      = out_q;
    carry_o    = carry_q;
    overflow_o = ovf_q;
    zero_o     = zero_q;
  end

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Scoreboard bench for seq_barrel_shifter (WIDTH=32, STEP=4).
// Stimulus pushes model results into a queue; the monitor checks each done pulse.
module tb_seq_barrel_shifter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;
  localparam int unsigned STEP  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  amt;
  logic [31:0] din;
  logic [31:0] out;
  logic        busy, done, carry, ovf, zero;

  always #5 clk = ~clk;

  seq_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW), .STEP(STEP)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .amt_i      (amt),
    .in_i       (din),
    .out_o      (out),
    .busy_o     (busy),
    .done_o     (done),
    .carry_o    (carry),
    .overflow_o (ovf),
    .zero_o     (zero)
  );

  typedef struct {
    logic [31:0] out;
    logic        c;
    logic        v;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the whole operation in one go; cyc holds the latency in edges.
  function automatic exp_t model(input logic [1:0] m, input logic [4:0] a,
                                 input logic [31:0] d);
    exp_t        r;
    int          n;
    logic [31:0] top, mask;
    n = int'(a);
    r.cyc = (n + int'(STEP) - 1) / int'(STEP);
    if (r.cyc < 1) r.cyc = 1;
    r.c = 1'b0;
    r.v = 1'b0;
    case (m)
      2'd0: begin
        r.out = d << n;
        if (n > 0) r.c = d[32-n];
        top  = d >> (31 - n);
        mask = 32'hFFFF_FFFF >> (31 - n);
        r.v  = (top != 0) && (top != mask);
      end
      2'd1: begin
        r.out = d >> n;
        if (n > 0) r.c = d[n-1];
      end
      2'd2: begin
        r.out = $signed(d) >>> n;
        if (n > 0) r.c = d[n-1];
      end
      default: begin
`ifdef SEQ_SHIFTER_ROR_EN
        r.out = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        if (n > 0) r.c = d[n-1];
`else
        r.out = d;
        r.cyc = 1;
`endif
      end
    endcase
    r.z = (r.out == 0);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", 64'(out), 64'(e.out));
        chk("carry", 64'(carry), 64'(e.c));
        chk("overflow", 64'(ovf), 64'(e.v));
        chk("zero", 64'(zero), 64'(e.z));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("busy_in_done", 64'(busy), 64'd0);
        held = e.out;
      end
    end
  end

  // Issue one operation; optionally pulse start again one cycle later (must be ignored).
  task automatic run_op(input logic [1:0] m, input logic [4:0] a, input logic [31:0] d,
                        input bit glitch);
    exp_t e;
    int   t;
    @(negedge clk);
    mode  = m;
    amt   = a;
    din   = d;
    start = 1'b1;
    e = model(m, a, d);
    e.cyc = cyc + 1 + e.cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("out_held", 64'(out), 64'(held));
    din  = $urandom;
    mode = 2'($urandom_range(0, 3));
    amt  = 5'($urandom_range(0, 31));
    if (glitch) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 64'd1, 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_out"}, 64'(out), 64'd0);
    chk({tag, "_carry"}, 64'(carry), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = '0;
    amt   = '0;
    din   = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Directed cases from the test plan.
    run_op(2'd0, 5'd1, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd0, 5'd1, 32'h4000_0000, 1'b0);
    run_op(2'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 5'd31, 32'h8000_0000, 1'b0);
    run_op(2'd1, 5'd31, 32'h8000_0000, 1'b0);
    run_op(2'd3, 5'd1, 32'h0000_0001, 1'b0);
    run_op(2'd1, 5'd20, 32'hDEAD_BEEF, 1'b1);
    run_op(2'd0, 5'd2, 32'h6000_0000, 1'b0);

    // Reset in the middle of a shift drops the operation.
    @(negedge clk);
    mode  = 2'd1;
    amt   = 5'd20;
    din   = 32'hFFFF_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    rst_n = 1'b1;
    held  = '0;
    repeat (8) @(negedge clk);

    // Reset wins over a simultaneous start.
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("reset_vs_start_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);

    run_op(2'd1, 5'd20, 32'h1234_5678, 1'b0);

    // Randomised operations, some with an ignored extra start pulse.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: d = 32'hFFFF_FFFF;
        1: d = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
        default: d = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), d,
             ($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_barrel_shifter.md
# seq_barrel_shifter

Multi-cycle, parametrised shifter for the ALU datapath. It generalises the 2-bit-mode barrel shifter in three ways: configurable data width, a full shift amount, and a configurable number of bits shifted per clock. Operations run under a start/busy/done handshake and produce carry, overflow and zero flags. The block sits beside the ALU and is driven by the control unit for all shift-class instructions.

## Interface
- WIDTH, 32, data width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).
- STEP, 1, bits shifted per clock; power of 2, 1..WIDTH.

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- amt  in  SHW  shift amount, 0..WIDTH-1.
- in  in  WIDTH  operand.
- out  out  WIDTH  result; valid while done=1 and held until the next accept.
- busy  out  1  high from the accept edge until done rises.
- done  out  1  one-cycle pulse; result and flags valid.
- carry  out  1  last bit shifted or rotated out; 0 when amt=0.
- overflow  out  1  LSL only: 1 if in[WIDTH-1 : WIDTH-1-amt] are not all equal (signed overflow); 0 for other modes.
- zero  out  1  out==0; updated together with out.

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 is an accept.
  - The accept latches in, mode and amt, sets rem=amt, sets busy=1 and moves to SHIFT.
- SHIFT, each edge:
  - Shift the working register by s=min(STEP, rem) in the latched mode.
  - Then rem -= s.
  - carry takes the last bit out:
    - LSL: bit WIDTH-s of the pre-step value.
    - LSR, ASR and ROR: bit s-1 of the pre-step value.
  - LSL overflow accumulates: set if any pre-step bit in the range [WIDTH-1 : WIDTH-1-s] differs from pre-step bit WIDTH-1.
  - The move to DONE happens on the edge where rem reaches 0 after the shift. With amt=0 it happens on the first SHIFT edge, with no shift and carry=0.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - out, carry, overflow and zero are loaded.
  - Next state is IDLE.
  - start is not accepted in DONE.
- ASR fills with the latched in[WIDTH-1]. ROR feeds back the bits it shifts out.
- start while busy or in DONE is ignored; the in-flight operation is unaffected.
- Result outputs change only on entry to DONE. They keep their value through IDLE and through the next operation until the next DONE.
- amt values of WIDTH or more cannot be represented with SHW bits, so no wrap handling is needed.

## Timing
- Accept edge E0: start=1 and state IDLE.
- k = ceil(amt/STEP). done is high in the cycle following edge E0+max(1,k).
- Examples:
  - amt=0: done after E1.
  - STEP=1, amt=31: done after E31.
  - STEP=4, amt=31: done after E8.
- Back-to-back rate: the next accept can happen at the earliest on the edge ending the DONE cycle plus one, i.e. in IDLE.
- Reset (rst_n=0 at an edge), in any state including mid-SHIFT:
  - state=IDLE, rem=0.
  - out=0, carry=0, overflow=0, zero=0.
  - busy=0, done=0.
  - The in-flight operation is dropped and no done pulse follows.
- If rst_n=0 and start=1 occur together, reset wins.

## Configuration
- SEQ_SHIFTER_ROR_EN defined: mode 11 performs rotate-right as described above.
- SEQ_SHIFTER_ROR_EN undefined:
  - Mode 11 is a pass-through: out=in, carry=0, overflow=0.
  - done follows the amt=0 timing (after E1) regardless of amt.
  - The rotate feedback logic is not synthesised.

## Test plan
- WIDTH=32, STEP=1, LSL, in=FFFFFFFF, amt=1 -> out=FFFFFFFE, carry=1, overflow=0, zero=0, done after E1.
- LSL, in=40000000, amt=1 -> out=80000000, carry=0, overflow=1. LSR, in=FFFFFFFF, amt=0 -> out=FFFFFFFF, carry=0, done after E1.
- STEP=4, ASR, in=80000000, amt=31 -> out=FFFFFFFF, carry=0, busy high for 8 cycles, done after E8. Same with LSR -> out=00000001.
- ROR, in=00000001, amt=1:
  - With SEQ_SHIFTER_ROR_EN -> out=80000000, carry=1.
  - Without it -> out=00000001, carry=0, done after E1.
- STEP=1, LSR, amt=20:
  - Pulse start again at E5 -> ignored; a single done after E20.
  - Drive rst_n=0 at E10 -> busy=0 and out=0 after E10, no done pulse.
  - Then a new accept completes normally.
